// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - ROM-driven fault-injection sequencer: UART sends, target sync, timed delays and glitch pulses.
module glitch_sequencer #(
  parameter int PROG_LEN   = 14,
  parameter int NUM_DELAYS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  instr_pt,
  input  logic [11:0] instr,
  output logic [7:0]  delay_num,
  input  logic [31:0] delay_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        rx_valid,
  output logic        glitch_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, SYNC, LOAD, DELAY, GLITCH, FINISH
  } state_t;

  localparam logic [7:0] END_PT = 8'(PROG_LEN);
  localparam logic [8:0] NUM_D  = 9'(NUM_DELAYS);

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [7:0]  arg_q;
  logic        sync_q;
  logic [31:0] count;
  logic        advance;
  logic        skip;
  logic        fetch_end;

  assign fetch_end = (instr_pt == END_PT) || !instr[9] || (instr[11:10] == 2'b11);
  // An out-of-range index is skipped regardless of what the table returns for it.
  assign skip      = (delay_len == 32'd0) || ({1'b0, arg_q} >= NUM_D);

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE:   if (start) state_next = FETCH;
      FETCH: begin
        if (fetch_end)                 state_next = FINISH;
        else if (instr[11:10] == 2'b00) state_next = SEND;
        else                           state_next = LOAD;
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (sync_q) state_next = SYNC;
          else        advance    = 1'b1;
        end
      end
      SYNC:   if (rx_valid) advance = 1'b1;
      LOAD: begin
        if (skip)                state_next = FETCH;
        else if (op_q == 2'b10)  state_next = GLITCH;
        else                     state_next = DELAY;
        advance = skip;
      end
      DELAY, GLITCH: if (count == 32'd1) advance = 1'b1;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (advance) state_next = FETCH;
    if (abort) begin
      state_next = IDLE;
      advance    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      instr_pt   <= 8'd0;
      delay_num  <= 8'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      glitch_out <= 1'b0;
      count      <= 32'd0;
      op_q       <= 2'd0;
      arg_q      <= 8'd0;
      sync_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH) begin
        op_q   <= instr[11:10];
        arg_q  <= instr[8:1];
        sync_q <= instr[0];
      end
      if (state == IDLE && state_next == FETCH) instr_pt <= 8'd0;
      if (advance) instr_pt <= instr_pt + 8'd1;
      if (state == FETCH && state_next == SEND) begin
        tx_data  <= instr[8:1];
        tx_valid <= 1'b1;
      end
      if (state == FETCH && state_next == LOAD) delay_num <= instr[8:1];
      if (state == SEND && tx_valid && tx_ready) tx_valid <= 1'b0;
      if (abort) tx_valid <= 1'b0;
      if (state == LOAD)
        count <= delay_len;
      else if ((state == DELAY || state == GLITCH) && count != 32'd0)
        count <= count - 32'd1;
      // Registered so the pulse width equals the number of cycles spent in GLITCH.
      glitch_out <= (state_next == GLITCH);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH) && !abort;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - directed self-checking bench for glitch_sequencer.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  instr_pt;
  logic [11:0] instr;
  logic [7:0]  delay_num;
  logic [31:0] delay_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        rx_valid = 1'b0;
  logic        glitch_out;
  logic        busy;
  logic        done;

  logic [11:0] rom [256];
  logic [31:0] dtab [256];

  int checks = 0;
  int errors = 0;

  assign instr     = rom[instr_pt];
  assign delay_len = dtab[delay_num];

  always #5 clk = ~clk;

  glitch_sequencer #(.PROG_LEN(14), .NUM_DELAYS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .instr_pt(instr_pt), .instr(instr), .delay_num(delay_num), .delay_len(delay_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .glitch_out(glitch_out), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 12'h000;
      dtab[i] = 32'd0;
    end
  endtask

  task automatic run_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  int gcnt, rises, p1, dn, hs, pt_done, fall_ok;
  logic prev_g, prev_done;

  initial begin
    clear_rom();
    // Reset state
    #12;
    chk("rst_instr_pt", instr_pt, 0);
    chk("rst_delay_num", delay_num, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_glitch", glitch_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    // Single SEND, no sync, tx_ready tied high
    rom[0] = 12'h308;
    run_start();
    chk("send_fetch_busy", busy, 1);
    chk("send_fetch_txv", tx_valid, 0);
    @(negedge clk);
    chk("send_txv", tx_valid, 1);
    chk("send_txdata", tx_data, 8'h84);
    chk("send_pt0", instr_pt, 0);
    @(negedge clk);
    chk("send_txv_drop", tx_valid, 0);
    chk("send_pt1", instr_pt, 1);
    @(negedge clk);
    chk("send_done", done, 1);
    chk("send_done_busy", busy, 1);
    @(negedge clk);
    chk("send_idle_busy", busy, 0);
    chk("send_idle_done", done, 0);

    // SEND with sync: backpressure, stray rx_valid in SEND, 50 cycles in SYNC
    clear_rom();
    rom[0] = 12'h2AB;
    tx_ready = 1'b0;
    run_start();
    @(negedge clk);
    chk("sync_txv", tx_valid, 1);
    chk("sync_txdata", tx_data, 8'h55);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("sync_hold_txv", tx_valid, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("sync_accept", tx_valid, 0);
    repeat (48) @(negedge clk);
    chk("sync_wait_pt", instr_pt, 0);
    chk("sync_wait_busy", busy, 1);
    @(negedge clk) rx_valid = 1'b1;
    @(negedge clk) rx_valid = 1'b0;
    chk("sync_advance_pt", instr_pt, 1);
    wait_idle("sync_idle", 20);

    // GLITCH of 8000 cycles, then a DELAY with out-of-range index
    clear_rom();
    rom[0]  = 12'hA00;
    rom[1]  = 12'h60A;
    dtab[0] = 32'h1F40;
    dtab[5] = 32'd100;
    run_start();
    gcnt = 0; rises = 0; p1 = 0; dn = 0; prev_g = 1'b0;
    for (int c = 0; c < 10000 && busy; c++) begin
      @(negedge clk);
      if (glitch_out) gcnt++;
      if (glitch_out && !prev_g) rises++;
      prev_g = glitch_out;
      if (busy && instr_pt == 8'd1) p1++;
      if (done) dn++;
    end
    chk("glitch_timeout", busy, 0);
    chk("glitch_cycles", gcnt, 8000);
    chk("glitch_rises", rises, 1);
    chk("delay5_cycles", p1, 2);
    chk("delay5_num", delay_num, 5);
    chk("glitch_done_cnt", dn, 1);

    // 14-entry program, all valid, entry 14 also valid
    clear_rom();
    for (int i = 0; i < 15; i++) begin
      case (i % 4)
        0: rom[i] = 12'h200 | 12'(i << 1);
        1: rom[i] = 12'h602;
        2: rom[i] = 12'h604;
        default: rom[i] = 12'hA06;
      endcase
    end
    dtab[1] = 32'd0;
    dtab[2] = 32'd3;
    dtab[3] = 32'd5;
    run_start();
    gcnt = 0; hs = 0; dn = 0; pt_done = 0; fall_ok = 0; prev_done = 1'b0;
    for (int c = 0; c < 2000 && busy; c++) begin
      @(negedge clk);
      if (glitch_out) gcnt++;
      if (tx_valid && tx_ready) hs++;
      if (done) begin
        dn++;
        pt_done = int'(instr_pt);
      end
      if (prev_done && !busy) fall_ok = 1;
      prev_done = done;
    end
    chk("prog_timeout", busy, 0);
    chk("prog_sends", hs, 4);
    chk("prog_glitch", gcnt, 15);
    chk("prog_done_cnt", dn, 1);
    chk("prog_pt_done", pt_done, 14);
    chk("prog_busy_fall", fall_ok, 1);
    chk("prog_delay_num", delay_num, 1);

    // Abort during GLITCH
    clear_rom();
    rom[0]  = 12'hA00;
    dtab[0] = 32'h1F40;
    run_start();
    for (int c = 0; c < 10 && !glitch_out; c++) @(negedge clk);
    chk("abort_glitch_on", glitch_out, 1);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_glitch_off", glitch_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    dn = 0; hs = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) hs++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_stay_idle", hs, 0);

    // Asynchronous reset in the middle of SEND
    clear_rom();
    rom[0] = 12'h308;
    tx_ready = 1'b0;
    run_start();
    @(negedge clk);
    chk("rstsend_txv", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstsend_txv_async", tx_valid, 0);
    chk("rstsend_busy", busy, 0);
    chk("rstsend_pt", instr_pt, 0);
    @(negedge clk) rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstsend_no_restart", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter PROG_LEN, default 14, meaning the number of program ROM entries executed before implicit end.
REQ-002 SHALL have parameter NUM_DELAYS, default 4, meaning the number of valid delay table entries.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  level sampled in IDLE; high begins a program run.
REQ-006 SHALL have port abort  input  1  high forces return to IDLE on the next edge.
REQ-007 SHALL have port instr_pt  output  8  program ROM address (registered).
REQ-008 SHALL have port instr  input  12  ROM word: [11:10] opcode, [9] valid, [8:1] arg, [0] sync.
REQ-009 SHALL have port delay_num  output  8  delay table index (registered).
REQ-010 SHALL have port delay_len  input  32  delay table word, in clk cycles.
REQ-011 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-012 SHALL have port tx_valid  output  1  tx_data is valid; held until accepted.
REQ-013 SHALL have port tx_ready  input  1  transmitter accepts when tx_valid and tx_ready are both high.
REQ-014 SHALL have port rx_valid  input  1  one-cycle pulse, a byte was received from the target.
REQ-015 SHALL have port glitch_out  output  1  registered glitch pulse to the power/clock switch.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse on program completion; not asserted on abort.

Function
REQ-018 SHALL implement states IDLE, FETCH, SEND, SYNC, LOAD, DELAY, GLITCH, FINISH.
REQ-019 SHALL leave IDLE when start=1: instr_pt<=0, next state FETCH.
REQ-020 SHALL in FETCH latch instr into an internal register (one cycle; ROM is combinational) and decode it on the following cycle.
REQ-021 SHALL go to FINISH if instr[9]=0, opcode=11, or instr_pt=PROG_LEN when entering FETCH.
REQ-022 SHALL for opcode 00 (SEND) drive tx_data=arg and tx_valid=1 until the cycle tx_valid&tx_ready; then go to SYNC if sync=1, else advance.
REQ-023 SHALL in SYNC wait with no timeout for rx_valid=1, then advance; rx_valid outside SYNC SHALL be ignored.
REQ-024 SHALL for opcode 01 (DELAY) and 10 (GLITCH) set delay_num=arg, then in LOAD (one cycle) load a 32-bit down-counter with delay_len.
REQ-025 SHALL in DELAY/GLITCH decrement the counter each cycle and advance after exactly delay_len cycles in that state.
REQ-026 SHALL hold glitch_out=1 for exactly delay_len cycles during GLITCH and 0 otherwise.
REQ-027 SHALL skip DELAY/GLITCH (advance directly from LOAD, glitch_out never asserted) when delay_len=0 or arg>=NUM_DELAYS.
REQ-028 SHALL on advance increment instr_pt by 1 (8-bit, no wrap beyond PROG_LEN per REQ-021) and return to FETCH.
REQ-029 SHALL in FINISH pulse done for one cycle, then go to IDLE; start held high SHALL NOT restart until seen in IDLE.
REQ-030 SHALL on abort (any state) deassert tx_valid and glitch_out and enter IDLE next edge; abort has priority over all transitions; tx_valid may drop before acceptance.

Reset
REQ-031 SHALL on rst_n=0 immediately enter IDLE with instr_pt=0, delay_num=0, tx_data=0, tx_valid=0, glitch_out=0, busy=0, done=0, counter=0.
REQ-032 SHALL resume from IDLE only after rst_n deasserts and start=1 is sampled; reset mid-GLITCH SHALL drop glitch_out asynchronously.

Verification
REQ-033 SHALL verify: ROM word 00_1_10000100_0, tx_ready tied 1 -> tx_valid high one cycle with tx_data=0x84, instr_pt advances 0->1.
REQ-034 SHALL verify: SEND with sync=1, tx_ready=1, rx_valid pulsed 50 cycles later -> FSM remains in SYNC 50 cycles, then instr_pt increments.
REQ-035 SHALL verify: GLITCH arg=0, delay_len=0x1F40 -> glitch_out high exactly 8000 consecutive cycles; delay arg=5 -> zero cycles, glitch_out never high.
REQ-036 SHALL verify: 14-entry program, all valid, delays shortened -> done pulses once after instr_pt reaches 14, busy falls the same cycle FSM enters IDLE.
REQ-037 SHALL verify: abort during GLITCH -> glitch_out 0 next edge, busy 0, no done pulse; rst_n low mid-SEND -> tx_valid 0 without waiting for clk.
